// File: rtl/bpred_update_sched.sv
// Branch-predictor update scheduler: arbitrates two requesters into a small FIFO and drains one update per cycle.
// Optional table-invalidate sweep after reset when BPRED_INIT_SWEEP_EN is defined.
module bpred_update_sched #(
  parameter int ADDR_WIDTH = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [31:0] a_pc,
  input  logic        a_is_br,
  input  logic        a_taken,
  input  logic [31:0] a_target,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [31:0] b_pc,
  input  logic        b_is_br,
  input  logic        b_taken,
  input  logic [31:0] b_target,
  output logic        upd_valid,
  output logic [31:0] upd_pc,
  output logic        upd_is_br,
  output logic        upd_taken,
  output logic [31:0] upd_target,
  output logic        init_busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FREE2_MAX = CW'(FIFO_DEPTH - 2);
  localparam logic [CW-1:0] FREE1_CNT = CW'(FIFO_DEPTH - 1);

  typedef struct packed {
    logic [31:0] pc;
    logic        is_br;
    logic        taken;
    logic [31:0] target;
  } entry_t;

  entry_t          mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            pri;       // 0: A has priority, 1: B has priority
  logic            run;
  logic            acc_a, acc_b, b_first, pop;
  logic [1:0]      push_n;
  entry_t          entry_a, entry_b, first, second;

`ifdef BPRED_INIT_SWEEP_EN
  typedef enum logic [0:0] {INIT, RUN} state_t;
  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] sweep_idx;
  logic                  sweep_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= INIT;
    else       state <= state_next;
  end

  // Leave INIT only once the last invalidate has been visible on upd_* for a full cycle.
  always_comb begin
    state_next = state;
    if (state == INIT && sweep_done) state_next = RUN;
  end

  assign run       = (state == RUN);
  assign init_busy = (state == INIT);
`else
  assign run       = 1'b1;
  assign init_busy = 1'b0;
`endif

  // Readiness uses start-of-cycle occupancy; the same-cycle pop is deliberately not credited.
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (run && !reset) begin
      if (count <= FREE2_MAX) begin
        a_ready = 1'b1;
        b_ready = 1'b1;
      end else if (count == FREE1_CNT) begin
        if (pri ? b_valid : a_valid) begin
          a_ready = !pri;
          b_ready = pri;
        end else begin
          a_ready = pri;
          b_ready = !pri;
        end
      end
    end
  end

  assign acc_a   = a_valid && a_ready;
  assign acc_b   = b_valid && b_ready;
  assign b_first = acc_b && (pri || !acc_a);
  assign push_n  = {1'b0, acc_a} + {1'b0, acc_b};
  assign pop     = run && (count != '0);
  assign entry_a = '{pc: a_pc, is_br: a_is_br, taken: a_taken, target: a_target};
  assign entry_b = '{pc: b_pc, is_br: b_is_br, taken: b_taken, target: b_target};
  assign first   = b_first ? entry_b : entry_a;
  assign second  = b_first ? entry_a : entry_b;

  always_ff @(posedge clk) begin
    if (push_n != 2'd0) mem[wr_ptr] <= first;
    if (push_n == 2'd2) mem[wr_ptr + PW'(1)] <= second;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      pri        <= 1'b0;
      upd_valid  <= 1'b0;
      upd_pc     <= '0;
      upd_is_br  <= 1'b0;
      upd_taken  <= 1'b0;
      upd_target <= '0;
`ifdef BPRED_INIT_SWEEP_EN
      sweep_idx  <= '0;
      sweep_done <= 1'b0;
`endif
    end else begin
      wr_ptr <= wr_ptr + PW'(push_n);
      count  <= count + CW'(push_n) - CW'(pop);
      if (pri ? acc_b : acc_a) pri <= !pri;
      if (run) begin
        if (pop) begin
          upd_valid  <= 1'b1;
          upd_pc     <= mem[rd_ptr].pc;
          upd_is_br  <= mem[rd_ptr].is_br;
          upd_taken  <= mem[rd_ptr].taken;
          upd_target <= mem[rd_ptr].target;
          rd_ptr     <= rd_ptr + PW'(1);
        end else begin
          upd_valid  <= 1'b0;
        end
      end
`ifdef BPRED_INIT_SWEEP_EN
      else if (sweep_done) begin
        upd_valid <= 1'b0;
      end else begin
        upd_valid  <= 1'b1;
        upd_pc     <= 32'({sweep_idx, 2'b00});
        upd_is_br  <= 1'b0;
        upd_taken  <= 1'b0;
        upd_target <= '0;
        sweep_idx  <= sweep_idx + ADDR_WIDTH'(1);
        if (sweep_idx == '1) sweep_done <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_bpred_update_sched.sv
// Directed bench for bpred_update_sched (ADDR_WIDTH=2, FIFO_DEPTH=4); covers both BPRED_INIT_SWEEP_EN builds.
module tb_bpred_update_sched;

  logic        clk, reset;
  logic        a_valid, a_ready, a_is_br, a_taken;
  logic        b_valid, b_ready, b_is_br, b_taken;
  logic [31:0] a_pc, a_target, b_pc, b_target;
  logic        upd_valid, upd_is_br, upd_taken, init_busy;
  logic [31:0] upd_pc, upd_target;

  int n_chk = 0;
  int n_err = 0;

  // Back-pressure table: both requesters hammer, then B drops, then both drop.
  bit tab_av [12] = '{1,1,1,1,1,1,1,0,0,0,0,0};
  bit tab_bv [12] = '{1,1,1,1,1,1,0,0,0,0,0,0};
  bit exp_ar [12] = '{1,1,0,1,0,1,1,1,1,1,1,1};
  bit exp_br [12] = '{1,1,1,0,1,0,0,0,1,1,1,1};
  bit exp_uv [12] = '{0,0,1,1,1,1,1,1,1,1,1,0};
  logic [31:0] exp_pc [12] = '{32'h0, 32'h0, 32'hB000, 32'hA000, 32'hA001, 32'hB001,
                               32'hB002, 32'hA003, 32'hB004, 32'hA005, 32'hA006, 32'hA006};

  bpred_update_sched #(.ADDR_WIDTH(2), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_pc(a_pc), .a_is_br(a_is_br),
    .a_taken(a_taken), .a_target(a_target),
    .b_valid(b_valid), .b_ready(b_ready), .b_pc(b_pc), .b_is_br(b_is_br),
    .b_taken(b_taken), .b_target(b_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_br(upd_is_br),
    .upd_taken(upd_taken), .upd_target(upd_target), .init_busy(init_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

`ifdef BPRED_INIT_SWEEP_EN
  // Starts in the cycle reset was released; ends in the first RUN cycle.
  task automatic run_sweep();
    chk("s0_init_busy", 32'(init_busy), 32'd1);
    chk("s0_a_ready", 32'(a_ready), 32'd0);
    chk("s0_upd_valid", 32'(upd_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("sw_upd_valid", 32'(upd_valid), 32'd1);
      chk("sw_upd_pc", upd_pc, 32'(i * 4));
      chk("sw_upd_is_br", 32'(upd_is_br), 32'd0);
      chk("sw_upd_target", upd_target, 32'd0);
      chk("sw_init_busy", 32'(init_busy), 32'd1);
      chk("sw_a_ready", 32'(a_ready), 32'd0);
    end
    tick();
    chk("sw_end_init_busy", 32'(init_busy), 32'd0);
    chk("sw_end_a_ready", 32'(a_ready), 32'd1);
    chk("sw_end_upd_valid", 32'(upd_valid), 32'd0);
  endtask
`endif

  initial begin
    reset = 1'b0;
    a_valid = 1'b1; a_pc = 32'h10; a_is_br = 1'b0; a_taken = 1'b0; a_target = '0;
    b_valid = 1'b1; b_pc = 32'h20; b_is_br = 1'b0; b_taken = 1'b0; b_target = '0;
    #1 reset = 1'b1;
    #1;
    chk("rst_upd_valid", 32'(upd_valid), 32'd0);
    chk("rst_upd_pc", upd_pc, 32'd0);
    chk("rst_a_ready", 32'(a_ready), 32'd0);
    chk("rst_b_ready", 32'(b_ready), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
`ifdef BPRED_INIT_SWEEP_EN
    run_sweep();
`endif
    // Simultaneous pair with priority A.
    chk("c0_a_ready", 32'(a_ready), 32'd1);
    chk("c0_b_ready", 32'(b_ready), 32'd1);
    chk("c0_init_busy", 32'(init_busy), 32'd0);
    tick(); a_valid = 1'b0; b_valid = 1'b0; #1;
    chk("c1_upd_valid", 32'(upd_valid), 32'd0);
    tick(); #1;
    chk("c2_upd_valid", 32'(upd_valid), 32'd1);
    chk("c2_upd_pc", upd_pc, 32'h10);
    tick(); a_valid = 1'b1; a_pc = 32'h30; b_valid = 1'b1; b_pc = 32'h40; #1;
    chk("c3_upd_pc", upd_pc, 32'h20);
    chk("c3_a_ready", 32'(a_ready), 32'd1);
    chk("c3_b_ready", 32'(b_ready), 32'd1);
    tick(); a_valid = 1'b0; b_valid = 1'b0; #1;
    chk("c4_upd_valid", 32'(upd_valid), 32'd0);
    tick(); #1;
    chk("c5_upd_pc_b_first", upd_pc, 32'h40);
    tick(); #1;
    chk("c6_upd_pc", upd_pc, 32'h30);
    // Single request, latency two cycles.
    tick(); a_valid = 1'b1; a_pc = 32'h100; a_is_br = 1'b1; a_taken = 1'b1; a_target = 32'h80; #1;
    chk("c7_upd_valid", 32'(upd_valid), 32'd0);
    chk("c7_a_ready", 32'(a_ready), 32'd1);
    tick(); a_valid = 1'b0; #1;
    chk("c8_upd_valid", 32'(upd_valid), 32'd0);
    tick(); #1;
    chk("c9_upd_valid", 32'(upd_valid), 32'd1);
    chk("c9_upd_pc", upd_pc, 32'h100);
    chk("c9_upd_taken", 32'(upd_taken), 32'd1);
    chk("c9_upd_is_br", 32'(upd_is_br), 32'd1);
    chk("c9_upd_target", upd_target, 32'h80);
    tick(); #1;
    chk("c10_upd_valid", 32'(upd_valid), 32'd0);
    chk("c10_upd_pc_hold", upd_pc, 32'h100);
    a_is_br = 1'b0; a_taken = 1'b0; a_target = '0;
    // Back-pressure: priority is B here.
    for (int i = 0; i < 12; i++) begin
      tick();
      a_valid = tab_av[i]; b_valid = tab_bv[i];
      a_pc = 32'h0000A000 + 32'(i); b_pc = 32'h0000B000 + 32'(i);
      #1;
      chk($sformatf("bp%0d_a_ready", i), 32'(a_ready), 32'(exp_ar[i]));
      chk($sformatf("bp%0d_b_ready", i), 32'(b_ready), 32'(exp_br[i]));
      chk($sformatf("bp%0d_upd_valid", i), 32'(upd_valid), 32'(exp_uv[i]));
      if (exp_uv[i] || i == 11) chk($sformatf("bp%0d_upd_pc", i), upd_pc, exp_pc[i]);
    end
    // Fill to three entries then reset mid-queue.
    tick(); a_valid = 1'b1; b_valid = 1'b1; a_pc = 32'hE0; b_pc = 32'hE1; #1;
    chk("e0_b_ready", 32'(b_ready), 32'd1);
    tick(); a_pc = 32'hE2; b_pc = 32'hE3; #1;
    chk("e1_a_ready", 32'(a_ready), 32'd1);
    tick(); a_valid = 1'b0; b_valid = 1'b0; #1;
    chk("e2_upd_pc", upd_pc, 32'hE1);
    reset = 1'b1; #1;
    chk("mid_rst_upd_valid", 32'(upd_valid), 32'd0);
    chk("mid_rst_upd_pc", upd_pc, 32'd0);
    chk("mid_rst_a_ready", 32'(a_ready), 32'd0);
    tick(); reset = 1'b0; #1;
`ifdef BPRED_INIT_SWEEP_EN
    tick(); tick(); #1;
    chk("ms_upd_pc_before", upd_pc, 32'h4);
    reset = 1'b1; #1;
    chk("ms_rst_upd_valid", 32'(upd_valid), 32'd0);
    chk("ms_rst_init_busy", 32'(init_busy), 32'd1);
    tick(); reset = 1'b0; #1;
    run_sweep();
`else
    chk("post_rst_upd_valid", 32'(upd_valid), 32'd0);
`endif
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("drained_upd_valid", 32'(upd_valid), 32'd0);
      chk("drained_init_busy", 32'(init_busy), 32'd0);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
